// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
// WIDTH and OPW are tied to the shared ALU and are not meant to be overridden.
package alu_arb_pkg;

  localparam int WIDTH = 6;
  localparam int OPW   = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // Requester index: 0 or 1.
  typedef logic owner_t;

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU: 00 add, 01 subtract, 10 and, 11 xor (all modulo 2**WIDTH).
module ALU
  import alu_arb_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   m,
  output logic [WIDTH-1:0] s
);

  always_comb begin
    s = '0;
    case (m)
      2'b00:   s = a + b;
      2'b01:   s = a - b;
      2'b10:   s = a & b;
      default: s = a ^ b;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters;
// a three-state FSM keeps a single operation in flight from accept to response.
module alu_share_arbiter
  import alu_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  input  logic             rsp1_ready,
  output logic             busy,
  output logic [7:0]       done0_cnt,
  output logic [7:0]       done1_cnt
);

  state_t           state_q, state_d;
  owner_t           last_grant_q, owner_q, grant_id;
  logic             grant_valid, rsp_take;
  logic [WIDTH-1:0] a_q, b_q, result_q, alu_s;
  logic [OPW-1:0]   op_q;

  // Grant: a lone requester wins; under contention the one not served last time wins.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant_id;
  assign req1_ready = grant_valid &&  grant_id;

  // Only the owner's rsp_ready can retire the response.
  assign rsp_take = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The ALU only ever sees the latched operands, never the live request buses.
  ALU u_alu (
    .a (a_q),
    .b (b_q),
    .m (op_q),
    .s (alu_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      if (grant_valid) begin
        a_q          <= grant_id ? req1_a  : req0_a;
        b_q          <= grant_id ? req1_b  : req0_b;
        op_q         <= grant_id ? req1_op : req0_op;
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) result_q <= alu_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_cnt <= '0;
      done1_cnt <= '0;
    end else if (rsp_take) begin
      if (owner_q) done1_cnt <= done1_cnt + 8'd1;
      else         done0_cnt <= done0_cnt + 8'd1;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: stimulus pushes expected responses,
// an independent monitor pops and compares them on every response handshake.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OPW-1:0]   req0_op = '0, req1_op = '0;
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic             busy;
  logic [7:0]       done0_cnt, done1_cnt;

  alu_share_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_ready (rsp1_ready),
    .busy       (busy),
    .done0_cnt  (done0_cnt),
    .done1_cnt  (done1_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit id; logic [WIDTH-1:0] data; } exp_t;
  typedef struct { bit id; int cyc; } glog_t;

  exp_t  exp_q[$];
  glog_t glog[$];
  exp_t  mon_e;
  int    n_pass = 0;
  int    n_total = 0;
  int    cyc_cnt = 0;

  // Hand-computed results for the operand sets used below.
  localparam logic [WIDTH-1:0] A0 = 6'b000110, B0 = 6'b001101;  // 6, 13
  localparam logic [WIDTH-1:0] A1 = 6'b010110, B1 = 6'b011101;  // 22, 29
  localparam logic [WIDTH-1:0] R0_ADD = 6'd19;
  localparam logic [WIDTH-1:0] R1_ADD = 6'd51;
  localparam logic [WIDTH-1:0] R1_SUB = 6'd57;  // 22 - 29 mod 64
  localparam logic [WIDTH-1:0] R1_AND = 6'b010100;
  localparam logic [WIDTH-1:0] R1_XOR = 6'b001011;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
  endtask

  always @(posedge clk) cyc_cnt++;

  // Request-handshake log, used for grant order and issue interval.
  always @(negedge clk) begin
    if (rst_n && req0_valid && req0_ready) glog.push_back('{1'b0, cyc_cnt});
    if (rst_n && req1_valid && req1_ready) glog.push_back('{1'b1, cyc_cnt});
  end

  // Response monitor: every taken response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: actual=response required=none (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_owner", {30'd0, rsp1_valid, rsp0_valid}, mon_e.id ? 32'd2 : 32'd1);
        check("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [OPW-1:0] op);
    if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
  endtask

  // Issue one operation, wait (bounded) for the grant, then drop valid.
  task automatic issue(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [OPW-1:0] op, input logic [WIDTH-1:0] res);
    bit got = 1'b0;
    exp_q.push_back('{id, res});
    set_req(id, a, b, op);
    #1;
    for (int i = 0; i < 50; i++) begin
      if (id ? req1_ready : req0_ready) begin got = 1'b1; break; end
      step();
    end
    if (!got) check("grant_timeout", 32'd0, 32'd1);
    step();
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) begin idle = 1'b1; break; end
      step();
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    do_reset();
    check("rst_req_ready", {req1_ready, req0_ready}, 0);
    check("rst_cnt", {done1_cnt, done0_cnt}, 0);
    check("rst_data", rsp0_data, 0);

    // Single request from requester 0
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    exp_q.push_back('{1'b0, R0_ADD});
    set_req(1'b0, A0, B0, 2'b00);
    #1;
    check("single_ready0", req0_ready, 1);
    check("single_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    #1;
    check("single_ready_drop", req0_ready, 0);
    check("single_exec_busy", busy, 1);
    check("single_exec_valid", rsp0_valid, 0);
    step();
    check("single_resp_valid", rsp0_valid, 1);
    check("single_resp_data", rsp0_data, R0_ADD);
    check("single_rsp1_quiet", rsp1_valid, 0);
    step();
    check("single_idle", busy, 0);
    check("single_cnt0", done0_cnt, 1);
    check("single_cnt1", done1_cnt, 0);

    // All four ops from requester 1
    issue(1'b1, A1, B1, 2'b00, R1_ADD); wait_idle();
    issue(1'b1, A1, B1, 2'b01, R1_SUB); wait_idle();
    issue(1'b1, A1, B1, 2'b10, R1_AND); wait_idle();
    issue(1'b1, A1, B1, 2'b11, R1_XOR); wait_idle();
    check("allops_cnt1", done1_cnt, 4);
    check("allops_cnt0", done0_cnt, 1);

    // Contention from reset: strict alternation starting with requester 0
    do_reset();
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{1'b0, R0_ADD});
      exp_q.push_back('{1'b1, R1_SUB});
    end
    set_req(1'b0, A0, B0, 2'b00);
    set_req(1'b1, A1, B1, 2'b01);
    for (int i = 0; i < 60; i++) begin
      step();
      if (glog.size() >= 6) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("cont_grants", glog.size(), 6);
    if (glog.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("cont_order", glog[i].id, i % 2);
      for (int i = 1; i < 6; i++) check("cont_interval", glog[i].cyc - glog[i-1].cyc, 3);
    end
    check("cont_cnt0", done0_cnt, 3);
    check("cont_cnt1", done1_cnt, 3);

    // Response backpressure on requester 0 with requester 1 waiting
    rsp0_ready = 1'b0;
    issue(1'b0, A0, B0, 2'b00, R0_ADD);
    exp_q.push_back('{1'b1, R1_AND});
    set_req(1'b1, A1, B1, 2'b10);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp0_valid, 1);
      check("bp_data", rsp0_data, R0_ADD);
      check("bp_busy", busy, 1);
      check("bp_req1_ready", req1_ready, 0);
      step();
    end
    rsp0_ready = 1'b1;
    step();
    check("bp_release_busy", busy, 0);
    check("bp_req1_granted", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    wait_idle();
    check("bp_cnt0", done0_cnt, 4);
    check("bp_cnt1", done1_cnt, 4);

    // Asynchronous reset while in EXEC
    set_req(1'b0, A0, B0, 2'b00);
    step();
    req0_valid = 1'b0;
    check("arst_exec_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("arst_cnt", {done1_cnt, done0_cnt}, 0);
    check("arst_data", rsp0_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("arst_no_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
      step();
    end
    exp_q.push_back('{1'b0, R0_ADD});
    exp_q.push_back('{1'b1, R1_XOR});
    set_req(1'b0, A0, B0, 2'b00);
    set_req(1'b1, A1, B1, 2'b11);
    #1;
    check("arst_first_grant", {req1_ready, req0_ready}, 2'b01);
    step();
    req0_valid = 1'b0;
    for (int i = 0; i < 20 && !req1_ready; i++) step();
    check("arst_second_grant", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    wait_idle();

    // Counter wrap after 256 completions from requester 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      issue(1'b0, A0, B0, 2'b00, R0_ADD);
      wait_idle();
      if (i == 254) check("wrap_cnt_255", done0_cnt, 255);
    end
    check("wrap_cnt_0", done0_cnt, 0);
    check("wrap_cnt1", done1_cnt, 0);

    repeat (2) step();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
